// File: rtl/rx_sync_pkg.sv
// ---------------------------------------------------------------------------
// rx_sync_pkg : shared state encoding, default parameters, counter widths
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rx_sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COARSE    = 3'd1,
    ST_TR_SEARCH = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int DEF_HOP_PERIOD     = 2600;
  localparam int DEF_NUM_SYNC_CHAN  = 8;
  localparam int DEF_COARSE_TO_HOPS = 64;
  localparam int DEF_TR_TO_CYCLES   = 10400;
  localparam int DEF_MAX_RETRY      = 3;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_hop_sched.sv
// ---------------------------------------------------------------------------
// rx_hop_sched : SYNC hop counter, channel stepping and hop-boundary pulse
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_hop_sched
  import rx_sync_pkg::*;
#(
  parameter int HOP_PERIOD    = DEF_HOP_PERIOD,
  parameter int NUM_SYNC_CHAN = DEF_NUM_SYNC_CHAN,
  parameter int MAX_HOPS      = DEF_COARSE_TO_HOPS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             clear,
  output logic [3:0]                       chan,
  output logic                             hop_en,
  output logic [cnt_width(MAX_HOPS)-1:0]   hop_count
);

  localparam int HP_W = cnt_width(HOP_PERIOD - 1);
  localparam int HN_W = cnt_width(MAX_HOPS);

  logic [HP_W-1:0] hop_cnt;

  // clear restarts the schedule and emits the entry pulse on channel 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hop_cnt   <= '0;
      chan      <= 4'd0;
      hop_en    <= 1'b0;
      hop_count <= '0;
    end else if (clear) begin
      hop_cnt   <= '0;
      chan      <= 4'd0;
      hop_en    <= 1'b1;
      hop_count <= '0;
    end else if (enable) begin
      if (hop_cnt == HP_W'(HOP_PERIOD - 1)) begin
        hop_cnt <= '0;
        hop_en  <= 1'b1;
        chan    <= (chan == 4'(NUM_SYNC_CHAN - 1)) ? 4'd0 : chan + 4'd1;
        if (hop_count != HN_W'(MAX_HOPS))
          hop_count <= hop_count + HN_W'(1);
      end else begin
        hop_cnt <= hop_cnt + HP_W'(1);
        hop_en  <= 1'b0;
      end
    end else begin
      hop_en <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// rx_sync_ctrl : coarse/TR acquisition sequencer with timeouts and retries
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_sync_ctrl
  import rx_sync_pkg::*;
#(
  parameter int HOP_PERIOD     = DEF_HOP_PERIOD,
  parameter int NUM_SYNC_CHAN  = DEF_NUM_SYNC_CHAN,
  parameter int COARSE_TO_HOPS = DEF_COARSE_TO_HOPS,
  parameter int TR_TO_CYCLES   = DEF_TR_TO_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic       logic_clk_in,
  input  logic       logic_rst_in,
  input  logic       start_in,
  input  logic       abort_in,
  input  logic       coarse_syn_success_in,
  input  logic [4:0] coarse_position_in,
  input  logic       tr_syn_success_in,
  input  logic       tr_syn_finish_in,
  input  logic [6:0] tr_position_in,
  output logic [3:0] sync_hop_chan_out,
  output logic       sync_pn_hop_en_out,
  output logic       tr_syn_en_out,
  output logic [4:0] coarse_pos_out,
  output logic [6:0] tr_pos_out,
  output logic       slot_lock_out,
  output logic       sync_ok_pulse_out,
  output logic       sync_fail_pulse_out,
  output logic [2:0] state_out,
  output logic [1:0] retry_cnt_out
);

  localparam int         HN_W      = cnt_width(COARSE_TO_HOPS);
  localparam int         TR_W      = cnt_width(TR_TO_CYCLES);
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

  state_t          state;
  logic [TR_W-1:0] tr_timer;
  logic [1:0]      retry_cnt;
  logic [HN_W-1:0] hop_count;

  logic in_coarse, in_tr, coarse_to, tr_to, attempt_fail, can_retry;
  logic hop_clear, hop_enable;

  assign in_coarse = (state == ST_COARSE);
  assign in_tr     = (state == ST_TR_SEARCH);
  assign coarse_to = (hop_count == HN_W'(COARSE_TO_HOPS));
  assign tr_to     = (tr_timer == TR_W'(TR_TO_CYCLES));
  assign can_retry = (retry_cnt < RETRY_LIM);

  // A hit or finish in the same cycle as a timeout takes precedence over it.
  assign attempt_fail = (in_coarse && !coarse_syn_success_in && coarse_to) ||
                        (in_tr && (tr_syn_finish_in ? !tr_syn_success_in : tr_to));

  assign hop_clear  = !abort_in && (start_in || (attempt_fail && can_retry));
  assign hop_enable = in_coarse && !abort_in && !start_in &&
                      !coarse_syn_success_in && !attempt_fail;

  rx_hop_sched #(
    .HOP_PERIOD    (HOP_PERIOD),
    .NUM_SYNC_CHAN (NUM_SYNC_CHAN),
    .MAX_HOPS      (COARSE_TO_HOPS)
  ) u_hop_sched (
    .clk       (logic_clk_in),
    .rst       (logic_rst_in),
    .enable    (hop_enable),
    .clear     (hop_clear),
    .chan      (sync_hop_chan_out),
    .hop_en    (sync_pn_hop_en_out),
    .hop_count (hop_count)
  );

  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      state               <= ST_IDLE;
      tr_timer            <= '0;
      retry_cnt           <= 2'd0;
      tr_syn_en_out       <= 1'b0;
      coarse_pos_out      <= 5'd0;
      tr_pos_out          <= 7'd0;
      slot_lock_out       <= 1'b0;
      sync_ok_pulse_out   <= 1'b0;
      sync_fail_pulse_out <= 1'b0;
    end else begin
      sync_ok_pulse_out   <= 1'b0;
      sync_fail_pulse_out <= 1'b0;
      if (abort_in) begin
        state         <= ST_IDLE;
        tr_syn_en_out <= 1'b0;
        slot_lock_out <= 1'b0;
      end else if (start_in) begin
        state         <= ST_COARSE;
        retry_cnt     <= 2'd0;
        tr_timer      <= '0;
        tr_syn_en_out <= 1'b0;
        slot_lock_out <= 1'b0;
      end else begin
        if (in_tr && !tr_to)
          tr_timer <= tr_timer + TR_W'(1);
        if (in_coarse && coarse_syn_success_in) begin
          coarse_pos_out <= coarse_position_in;
          state          <= ST_TR_SEARCH;
          tr_syn_en_out  <= 1'b1;
          tr_timer       <= '0;
        end else if (in_tr && tr_syn_finish_in && tr_syn_success_in) begin
          tr_pos_out        <= tr_position_in;
          state             <= ST_LOCKED;
          tr_syn_en_out     <= 1'b0;
          slot_lock_out     <= 1'b1;
          sync_ok_pulse_out <= 1'b1;
        end else if (attempt_fail) begin
          tr_syn_en_out <= 1'b0;
          if (can_retry) begin
            retry_cnt <= retry_cnt + 2'd1;
            state     <= ST_COARSE;
          end else begin
            state               <= ST_FAIL;
            sync_fail_pulse_out <= 1'b1;
          end
        end
      end
    end
  end

  assign state_out     = state;
  assign retry_cnt_out = retry_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_sync_ctrl : directed scenarios, pulse events checked via scoreboard
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx_sync_ctrl;

  localparam int HOP = 10;
  localparam int CTO = 4;
  localparam int TTO = 20;
  localparam int MR  = 1;

  localparam int EV_HOP  = 0;
  localparam int EV_OK   = 1;
  localparam int EV_FAIL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic       c_succ = 1'b0, tr_succ = 1'b0, tr_fin = 1'b0;
  logic [4:0] c_pos = 5'd0;
  logic [6:0] t_pos = 7'd0;

  logic [3:0] chan;
  logic       hop_en, tr_en, lock, ok_p, fail_p;
  logic [4:0] coarse_pos;
  logic [6:0] tr_pos;
  logic [2:0] state;
  logic [1:0] retry;

  rx_sync_ctrl #(
    .HOP_PERIOD     (HOP),
    .NUM_SYNC_CHAN  (8),
    .COARSE_TO_HOPS (CTO),
    .TR_TO_CYCLES   (TTO),
    .MAX_RETRY      (MR)
  ) dut (
    .logic_clk_in          (clk),
    .logic_rst_in          (rst),
    .start_in              (start),
    .abort_in              (abort),
    .coarse_syn_success_in (c_succ),
    .coarse_position_in    (c_pos),
    .tr_syn_success_in     (tr_succ),
    .tr_syn_finish_in      (tr_fin),
    .tr_position_in        (t_pos),
    .sync_hop_chan_out     (chan),
    .sync_pn_hop_en_out    (hop_en),
    .tr_syn_en_out         (tr_en),
    .coarse_pos_out        (coarse_pos),
    .tr_pos_out            (tr_pos),
    .slot_lock_out         (lock),
    .sync_ok_pulse_out     (ok_p),
    .sync_fail_pulse_out   (fail_p),
    .state_out             (state),
    .retry_cnt_out         (retry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic push(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ev_chk(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected none",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        failures++;
        $display("FAIL event: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: pops one expected event per pulse the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (hop_en) ev_chk(EV_HOP, int'(chan));
      if (ok_p)   ev_chk(EV_OK, int'({coarse_pos, tr_pos}));
      if (fail_p) ev_chk(EV_FAIL, int'(retry));
    end
  end

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    at(2);
    chk("rst_state", int'(state), 0);
    chk("rst_chan", int'(chan), 0);
    chk("rst_tr_en", int'(tr_en), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_retry", int'(retry), 0);
    rst = 1'b0;

    // 1: clean acquisition
    push(EV_HOP, 6, 0);
    push(EV_HOP, 16, 1);
    push(EV_HOP, 26, 2);
    push(EV_OK, 41, 17 * 128 + 99);
    at(5);  start = 1'b1;
    at(6);  start = 1'b0;
    chk("t1_state_coarse", int'(state), 1);
    at(30); c_succ = 1'b1; c_pos = 5'd17;
    at(31); c_succ = 1'b0;
    chk("t1_tr_en_first", int'(tr_en), 1);
    chk("t1_coarse_pos", int'(coarse_pos), 17);
    at(40);
    chk("t1_tr_en_last", int'(tr_en), 1);
    tr_fin = 1'b1; tr_succ = 1'b1; t_pos = 7'd99;
    at(41); tr_fin = 1'b0; tr_succ = 1'b0;
    chk("t1_tr_en_off", int'(tr_en), 0);
    chk("t1_lock", int'(lock), 1);
    chk("t1_state_locked", int'(state), 3);
    chk("t1_tr_pos", int'(tr_pos), 99);

    // 3: TR finish without success, then a successful retry
    push(EV_HOP, 46, 0);
    push(EV_HOP, 54, 0);
    push(EV_OK, 61, 9 * 128 + 42);
    at(45); start = 1'b1;
    at(46); start = 1'b0;
    at(48); c_succ = 1'b1; c_pos = 5'd5;
    at(49); c_succ = 1'b0;
    chk("t3_state_tr", int'(state), 2);
    at(53); tr_fin = 1'b1; tr_succ = 1'b0;
    at(54); tr_fin = 1'b0;
    chk("t3_state_retry", int'(state), 1);
    chk("t3_retry_cnt", int'(retry), 1);
    at(57); c_succ = 1'b1; c_pos = 5'd9;
    at(58); c_succ = 1'b0;
    at(60); tr_fin = 1'b1; tr_succ = 1'b1; t_pos = 7'd42;
    at(61); tr_fin = 1'b0; tr_succ = 1'b0;
    chk("t3_state_locked", int'(state), 3);
    chk("t3_retry_locked", int'(retry), 1);
    chk("t3_coarse_pos", int'(coarse_pos), 9);

    // 4: TR timeout, retry restarts on channel 0, then lock
    push(EV_HOP, 66, 0);
    push(EV_HOP, 89, 0);
    push(EV_OK, 96, 1 * 128 + 2);
    at(65); start = 1'b1;
    at(66); start = 1'b0;
    at(67); c_succ = 1'b1; c_pos = 5'd3;
    at(68); c_succ = 1'b0;
    at(88);
    chk("t4_still_tr", int'(state), 2);
    at(89);
    chk("t4_state_retry", int'(state), 1);
    chk("t4_tr_en_off", int'(tr_en), 0);
    chk("t4_chan", int'(chan), 0);
    chk("t4_retry_cnt", int'(retry), 1);
    at(91); c_succ = 1'b1; c_pos = 5'd1;
    at(92); c_succ = 1'b0;
    at(95); tr_fin = 1'b1; tr_succ = 1'b1; t_pos = 7'd2;
    at(96); tr_fin = 1'b0; tr_succ = 1'b0;
    chk("t4_state_locked", int'(state), 3);

    // 5: abort beats start while LOCKED
    at(100); start = 1'b1; abort = 1'b1;
    at(101); start = 1'b0; abort = 1'b0;
    chk("t5_state_idle", int'(state), 0);
    chk("t5_lock_off", int'(lock), 0);
    at(110);
    chk("t5_idle_held", int'(state), 0);

    // 2: no coarse hit -> two attempts then FAIL
    for (int a = 0; a < 2; a++)
      for (int k = 0; k <= CTO; k++)
        push(EV_HOP, 116 + 41 * a + HOP * k, k);
    push(EV_FAIL, 198, 1);
    at(115); start = 1'b1;
    at(116); start = 1'b0;
    at(197);
    chk("t2_second_attempt", int'(state), 1);
    at(198);
    chk("t2_state_fail", int'(state), 4);
    chk("t2_retry_cnt", int'(retry), 1);
    at(204);
    chk("t2_fail_held", int'(state), 4);

    // 6: asynchronous reset mid-COARSE
    push(EV_HOP, 206, 0);
    push(EV_HOP, 216, 1);
    at(205); start = 1'b1;
    at(206); start = 1'b0;
    at(220);
    rst = 1'b1;
    #2;
    chk("t6_state", int'(state), 0);
    chk("t6_chan", int'(chan), 0);
    chk("t6_hop_en", int'(hop_en), 0);
    chk("t6_tr_en", int'(tr_en), 0);
    chk("t6_coarse_pos", int'(coarse_pos), 0);
    chk("t6_tr_pos", int'(tr_pos), 0);
    chk("t6_lock", int'(lock), 0);
    chk("t6_pulses", int'({ok_p, fail_p}), 0);
    chk("t6_retry", int'(retry), 0);
    at(223); rst = 1'b0;
    at(240);
    chk("t6_idle_after", int'(state), 0);
    chk("t6_chan_after", int'(chan), 0);

    chk("events_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
